rr_arbiter8: RTL and testbench

- Round-robin arbiter that shares one resource among 8 requesters.
- Holds a registered 3-bit grant index and expands it to a one-hot 8-bit grant through an enabled 3-to-8 decode stage.
- Sits between requesting masters and a single shared target, such as a bus, memory port or output stage.
- Fairness is round-robin: a requester that keeps its request high is guaranteed service within 7 other grants.

---
 rtl/arb_pkg.sv | 16 +
 rtl/rr_arbiter8_if.sv | 16 +
 rtl/arb_idx_decoder.sv | 13 +
 rtl/rr_arbiter8.sv | 67 ++++++
 tb/tb_rr_arbiter8.sv | 128 ++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared constants, state type and round-robin pick function for rr_arbiter8
package arb_pkg;
    localparam int NREQ = 8;
    localparam int IDXW = 3;
    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;
    // Searches upward from last+1, wrapping; the 3-bit sum wraps 7 -> 0 by itself.
    // Scanning down from the farthest offset lets the nearest set bit win.
    function automatic logic [IDXW-1:0] rr_pick(input logic [NREQ-1:0] req, input logic [IDXW-1:0] last);
        logic [IDXW-1:0] k;
        rr_pick = last;
        for (int i = NREQ; i >= 1; i--) begin
            k = last + IDXW'(i);
            if (req[k]) rr_pick = k;
        end
    endfunction
endpackage

// File: rtl/rr_arbiter8_if.sv
// rr_arbiter8_if: request/grant bundle between requesting masters and the arbiter
//   req       requester -> arbiter, one line per requester
//   gnt       one-hot grant, zero when idle
//   gnt_idx   index of the current or most recent grant
//   gnt_valid a grant is active
//   timeout   one-cycle pulse on a forced release
interface rr_arbiter8_if;
    import arb_pkg::*;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [IDXW-1:0] gnt_idx;
    logic            gnt_valid;
    logic            timeout;
    modport master (output req, input gnt, gnt_idx, gnt_valid, timeout);
    modport slave (input req, output gnt, gnt_idx, gnt_valid, timeout);
endinterface

// File: rtl/arb_idx_decoder.sv
// arb_idx_decoder: combinational 3-to-8 decode with enable
//   gnt_idx_i   index to decode
//   gnt_valid_i enable; output is all zeros when low
//   gnt_o       one-hot result
module arb_idx_decoder
    import arb_pkg::*;
(
    input  logic [IDXW-1:0] gnt_idx_i,
    input  logic            gnt_valid_i,
    output logic [NREQ-1:0] gnt_o
);
    assign gnt_o = gnt_valid_i ? NREQ'(1) << gnt_idx_i : '0;
endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with a registered grant index and a dead cycle between grants
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  rr_arbiter8_if.slave: req in; gnt, gnt_idx, gnt_valid, timeout out
// Optional ARB_TIMEOUT_EN: adds parameter TIMEOUT (2..255) and force-releases a grant
// held for TIMEOUT cycles; without it grants are held indefinitely and timeout is 0.
module rr_arbiter8
    import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
    #(parameter int TIMEOUT = 16)
`endif
(
    input  logic         clk,
    input  logic         rst,
    rr_arbiter8_if.slave bus
);
    arb_state_e      state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d, last_q, last_d;
    logic            to_hit;
    logic            rel;
    always_comb begin
        rel     = state_q == ARB_GRANT && (!bus.req[idx_q] || to_hit);
        state_d = state_q == ARB_IDLE ? (|bus.req ? ARB_GRANT : ARB_IDLE) : (rel ? ARB_IDLE : ARB_GRANT);
        idx_d   = state_q == ARB_IDLE && |bus.req ? rr_pick(bus.req, last_q) : idx_q;
        last_d  = rel ? idx_q : last_q;
    end
    // last resets to 7 so requester 0 wins the first arbitration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            idx_q   <= '0;
            last_q  <= '1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end
`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       tmo_q;
    // A still-requesting owner is cut off after TIMEOUT cycles of grant
    assign to_hit = state_q == ARB_GRANT && bus.req[idx_q] && cnt_q == 8'(TIMEOUT - 1);
    assign cnt_d  = state_q == ARB_GRANT ? cnt_q + 8'd1 : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= to_hit;
        end
    end
    assign bus.timeout = tmo_q;
`else
    assign to_hit      = 1'b0;
    assign bus.timeout = 1'b0;
`endif
    assign bus.gnt_valid = state_q == ARB_GRANT;
    assign bus.gnt_idx   = idx_q;
    // Decoded from registers only, so gnt cannot glitch
    arb_idx_decoder u_dec (
        .gnt_idx_i   (idx_q),
        .gnt_valid_i (state_q == ARB_GRANT),
        .gnt_o       (bus.gnt)
    );
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed and random checks of rr_arbiter8 against a behavioural model
module tb_rr_arbiter8;
    logic clk = 1'b0;
    logic rst;
    int   nvec = 0;
    int   nerr = 0;
    int   m_own;
    int   m_last;
    int   m_idx;
    always #5 clk = ~clk;
    rr_arbiter8_if bus ();
    rr_arbiter8 dut (.clk(clk), .rst(rst), .bus(bus.slave));
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        nvec++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask
    // Model: m_own is the requester holding the resource (-1 = none); a new owner
    // can only be chosen from the idle state, scanning the ring starting after m_last.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_own  = -1;
            m_last = 7;
            m_idx  = 0;
        end else if (m_own < 0) begin
            for (int k = 1; k <= 8 && m_own < 0; k++)
                if (bus.req[(m_last + k) % 8]) m_own = (m_last + k) % 8;
            if (m_own >= 0) m_idx = m_own;
        end else if (!bus.req[m_own]) begin
            m_last = m_own;
            m_own  = -1;
        end
    end
    always @(negedge clk) begin
        chk("gnt", {24'd0, bus.gnt}, m_own < 0 ? 32'd0 : 32'd1 << m_own);
        chk("gnt_valid", {31'd0, bus.gnt_valid}, {31'd0, m_own >= 0});
        chk("gnt_idx", {29'd0, bus.gnt_idx}, m_idx);
        chk("onehot0", {31'd0, $onehot0(bus.gnt)}, 32'd1);
        chk("valid_vs_gnt", {31'd0, bus.gnt_valid}, {31'd0, |bus.gnt});
        chk("timeout", {31'd0, bus.timeout}, 32'd0);
    end
    initial begin
        rst = 1'b0;
        bus.req = 8'hFF;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_gnt", {24'd0, bus.gnt}, 32'h00);
        chk("rst_valid", {31'd0, bus.gnt_valid}, 32'd0);
        chk("rst_idx", {29'd0, bus.gnt_idx}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        // full contention: owner drops after 3 grant cycles and re-raises during the dead cycle
        for (int w = 0; w <= 8; w++) begin
            chk("rr_order", {24'd0, bus.gnt}, 32'd1 << (w % 8));
            repeat (2) @(negedge clk);
            bus.req[w % 8] = 1'b0;
            @(negedge clk);
            chk("rr_dead", {24'd0, bus.gnt}, 32'h00);
            bus.req[w % 8] = 1'b1;
            @(negedge clk);
        end
        chk("rr_wrap_order", {24'd0, bus.gnt}, 32'h02);
        bus.req = 8'h00;
        @(negedge clk);
        // single requester held 5 cycles, then drop and re-raise
        bus.req = 8'h10;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                chk("single_hold", {24'd0, bus.gnt}, 32'h10);
            end
            bus.req = 8'h00;
            @(negedge clk);
            chk("single_drop", {24'd0, bus.gnt}, 32'h00);
            bus.req = 8'h10;
        end
        bus.req = 8'h00;
        @(negedge clk);
        // make last = 6, then 0 must win by wrapping before 6
        bus.req = 8'h40;
        @(negedge clk);
        chk("wrap_setup", {24'd0, bus.gnt}, 32'h40);
        bus.req = 8'h00;
        @(negedge clk);
        bus.req = 8'h41;
        @(negedge clk);
        chk("wrap_first", {24'd0, bus.gnt}, 32'h01);
        bus.req = 8'h40;
        @(negedge clk);
        chk("wrap_dead", {24'd0, bus.gnt}, 32'h00);
        @(negedge clk);
        chk("wrap_second", {24'd0, bus.gnt}, 32'h40);
        bus.req = 8'h00;
        @(negedge clk);
        // asynchronous reset in the middle of a grant
        bus.req = 8'h08;
        @(negedge clk);
        chk("async_pre", {24'd0, bus.gnt}, 32'h08);
        #2 rst = 1'b1;
        #1 chk("async_gnt", {24'd0, bus.gnt}, 32'h00);
        chk("async_valid", {31'd0, bus.gnt_valid}, 32'd0);
        bus.req = 8'h0A;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("async_after", {24'd0, bus.gnt}, 32'h02);
        bus.req = 8'h00;
        @(negedge clk);
        // without a timeout a held grant is never released
        bus.req = 8'h03;
        repeat (40) @(negedge clk);
        chk("hold_forever", {24'd0, bus.gnt}, 32'h01);
        bus.req = 8'h00;
        @(negedge clk);
        // random traffic: owner keeps its request with probability 3/4
        repeat (3000) begin
            for (int i = 0; i < 8; i++)
                bus.req[i] = (i == m_own) ? ($urandom_range(3) != 0) : ($urandom_range(2) == 0);
            @(negedge clk);
        end
        bus.req = 8'h00;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
